// File: rtl/w0rm_synchro_fifo_if.sv
// w0rm_synchro_fifo_if: valid/ready handshake bundle between producer, buffer and consumer.
//   input_valid/input_ready/input_data    : producer -> buffer transfer
//   output_valid/output_ready/output_data : buffer -> consumer transfer
//   master modport: the producer/consumer side, slave modport: the buffer itself.
interface w0rm_synchro_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  input_valid;
    logic                  input_ready;
    logic [DATA_WIDTH-1:0] input_data;
    logic                  output_valid;
    logic                  output_ready;
    logic [DATA_WIDTH-1:0] output_data;

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_data
    );

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_data
    );
endinterface

// File: rtl/w0rm_synchro_fifo.sv
// w0rm_synchro_fifo: DEPTH-entry first-word-fall-through valid/ready elastic buffer.
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset (pointers and count to zero)
//   flush       : synchronous discard of all contents, blocks push/pop that cycle
//   bus         : handshake bundle (slave modport) carrying both transfer sides
//   count       : current occupancy 0..DEPTH
//   almost_full : count >= AFULL_LEVEL, derived from registered count only
module w0rm_synchro_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_READY  = 1,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    w0rm_synchro_fifo_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Power-of-two depth lets the pointers wrap naturally at DEPTH-1 -> 0.
    always_comb begin
        full             = count == CW'(DEPTH);
        bus.input_ready  = !reset && !flush && (!full || (SYNC_READY == 0 && bus.output_ready));
        bus.output_valid = count != '0;
        bus.output_data  = bus.output_valid ? mem[rd_ptr] : '0;
        push             = bus.input_valid && bus.input_ready;
        pop              = bus.output_valid && bus.output_ready && !flush && !reset;
        almost_full      = count >= CW'(AFULL_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; push is already blocked during reset and flush.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.input_data;
    end
endmodule

// File: tb/tb_w0rm_synchro_fifo.sv
// tb_w0rm_synchro_fifo: vector table plus hand sequences for the elastic buffer.
module tb_w0rm_synchro_fifo;
    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
        logic       e_af;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush_a = 1'b0;
    logic       flush_b = 1'b0;
    logic [2:0] count_a, count_b;
    logic       afull_a, afull_b;
    int         tests = 0;
    int         failed = 0;
    vec_t       vecs[$];

    w0rm_synchro_fifo_if #(.DATA_WIDTH(8)) ifa ();
    w0rm_synchro_fifo_if #(.DATA_WIDTH(8)) ifb ();

    w0rm_synchro_fifo #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_READY(1), .AFULL_LEVEL(3)) dut_a (
        .clk(clk), .reset(reset), .flush(flush_a), .bus(ifa.slave),
        .count(count_a), .almost_full(afull_a)
    );

    w0rm_synchro_fifo #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_READY(0), .AFULL_LEVEL(3)) dut_b (
        .clk(clk), .reset(reset), .flush(flush_b), .bus(ifb.slave),
        .count(count_b), .almost_full(afull_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rst, fl, iv, input logic [7:0] id, input logic ordy,
                               input logic e_ir, e_ov, input logic [7:0] e_od,
                               input logic [2:0] e_cnt, input logic e_af);
        vec_t r;
        r.rst = rst; r.fl = fl; r.iv = iv; r.id = id; r.ordy = ordy;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_cnt = e_cnt; r.e_af = e_af;
        return r;
    endfunction

    initial begin
        logic [7:0] q[$];
        int nxt, rx;
        logic pop_now;
        void'($urandom(32'd7));
        ifa.input_valid = 1'b0; ifa.input_data = '0; ifa.output_ready = 1'b0;
        ifb.input_valid = 1'b0; ifb.input_data = '0; ifb.output_ready = 1'b0;
        // reset hold, 3 cycles with input_valid high, then release
        vecs.push_back(v('1, '0, '1, 8'hFF, '0, '0, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('1, '0, '1, 8'hFF, '0, '0, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('1, '0, '1, 8'hFF, '0, '0, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('0, '0, '0, 8'h00, '0, '1, '0, 8'h00, 3'd0, '0));
        // fill 4 then attempt a push while full, then drain
        vecs.push_back(v('0, '0, '1, 8'h11, '0, '1, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('0, '0, '1, 8'h22, '0, '1, '1, 8'h11, 3'd1, '0));
        vecs.push_back(v('0, '0, '1, 8'h33, '0, '1, '1, 8'h11, 3'd2, '0));
        vecs.push_back(v('0, '0, '1, 8'h44, '0, '1, '1, 8'h11, 3'd3, '1));
        vecs.push_back(v('0, '0, '1, 8'h55, '0, '0, '1, 8'h11, 3'd4, '1));
        vecs.push_back(v('0, '0, '0, 8'h00, '1, '0, '1, 8'h11, 3'd4, '1));
        vecs.push_back(v('0, '0, '0, 8'h00, '1, '1, '1, 8'h22, 3'd3, '1));
        vecs.push_back(v('0, '0, '0, 8'h00, '1, '1, '1, 8'h33, 3'd2, '0));
        vecs.push_back(v('0, '0, '0, 8'h00, '1, '1, '1, 8'h44, 3'd1, '0));
        vecs.push_back(v('0, '0, '0, 8'h00, '0, '1, '0, 8'h00, 3'd0, '0));
        // flush at count 3 with push and pop presented
        vecs.push_back(v('0, '0, '1, 8'hC1, '0, '1, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('0, '0, '1, 8'hC2, '0, '1, '1, 8'hC1, 3'd1, '0));
        vecs.push_back(v('0, '0, '1, 8'hC3, '0, '1, '1, 8'hC1, 3'd2, '0));
        vecs.push_back(v('0, '1, '1, 8'hD0, '1, '0, '1, 8'hC1, 3'd3, '1));
        vecs.push_back(v('0, '0, '0, 8'h00, '0, '1, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('0, '0, '1, 8'h5A, '0, '1, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('0, '0, '0, 8'h00, '1, '1, '1, 8'h5A, 3'd1, '0));
        // empty latency: push with output_ready already high
        vecs.push_back(v('0, '0, '1, 8'h7E, '1, '1, '0, 8'h00, 3'd0, '0));
        vecs.push_back(v('0, '0, '0, 8'h00, '1, '1, '1, 8'h7E, 3'd1, '0));
        vecs.push_back(v('0, '0, '0, 8'h00, '0, '1, '0, 8'h00, 3'd0, '0));

        @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; flush_a = vecs[i].fl;
            ifa.input_valid = vecs[i].iv; ifa.input_data = vecs[i].id; ifa.output_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_input_ready", i), 32'(ifa.input_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_output_valid", i), 32'(ifa.output_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_output_data", i), 32'(ifa.output_data), 32'(vecs[i].e_od));
            chk($sformatf("vec%0d_count", i), 32'(count_a), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_almost_full", i), 32'(afull_a), 32'(vecs[i].e_af));
        end
        @(negedge clk);
        flush_a = 1'b0; ifa.input_valid = 1'b0; ifa.output_ready = 1'b0;

        // full pass-through on the SYNC_READY=0 instance
        for (int i = 0; i < 4; i++) begin
            ifb.input_valid = 1'b1; ifb.input_data = 8'hA0 + 8'(i); ifb.output_ready = 1'b0;
            #1 chk("pt_fill_ready", 32'(ifb.input_ready), 32'd1);
            @(negedge clk);
        end
        ifb.input_data = 8'hB0;
        #1;
        chk("pt_full_blocked", 32'(ifb.input_ready), 32'd0);
        chk("pt_full_count", 32'(count_b), 32'd4);
        ifb.output_ready = 1'b1;
        #1;
        chk("pt_ready_when_popping", 32'(ifb.input_ready), 32'd1);
        chk("pt_head", 32'(ifb.output_data), 32'hA0);
        @(negedge clk);
        ifb.input_valid = 1'b0;
        #1 chk("pt_count_held", 32'(count_b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("pt_drain_data", 32'(ifb.output_data), (i < 3) ? 32'hA1 + 32'(i) : 32'hB0);
            @(negedge clk);
            #1;
        end
        chk("pt_empty", 32'(count_b), 32'd0);
        ifb.output_ready = 1'b0;

        // random stream against a queue model
        nxt = 0; rx = 0;
        for (int cyc = 0; cyc < 2000 && rx < 20; cyc++) begin
            @(negedge clk);
            ifa.input_valid = (nxt < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            ifa.input_data = 8'(nxt);
            ifa.output_ready = 1'($urandom_range(0, 1));
            #1;
            chk("wrap_input_ready", 32'(ifa.input_ready), 32'(q.size() != 4));
            chk("wrap_output_valid", 32'(ifa.output_valid), 32'(q.size() != 0));
            chk("wrap_count", 32'(count_a), 32'(q.size()));
            pop_now = q.size() != 0 && ifa.output_ready;
            if (pop_now) begin
                chk("wrap_order", 32'(ifa.output_data), 32'(rx));
                void'(q.pop_front());
                rx++;
            end
            if (ifa.input_valid && (q.size() != 4 || pop_now) && (q.size() + (pop_now ? 1 : 0)) != 4) begin
                q.push_back(8'(nxt));
                nxt++;
            end
        end
        chk("wrap_done", 32'(rx), 32'd20);
        @(negedge clk);
        ifa.input_valid = 1'b0; ifa.output_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
